// File: rtl/spi_driver_pkg.sv
// Shared constants, state encoding and frame-length helper for the SPI master.
package spi_driver_pkg;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int HDR_BITS = 9;
    localparam int CNT_W    = 16;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        RDATA,
        DONE
    } state_t;

    // Total SPI bits in a frame: header plus one byte (write) or N bytes (read).
    function automatic logic [CNT_W-1:0] frame_bits(input logic wr, input logic [DATA_W-1:0] n);
        if (wr)
            return CNT_W'(HDR_BITS + DATA_W);
        return CNT_W'(HDR_BITS) + {5'd0, n, 3'd0};
    endfunction
endpackage

// File: rtl/spi_driver.sv
// SPI master: serialises a write or burst-read command and deserialises returned
// bytes into a FIFO write strobe. One SPI bit spans two clk cycles.
module spi_driver
    import spi_driver_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              serial_in,
    input  logic              new_command,
    input  logic [ADDR_W-1:0] write_register_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] num_regs_to_read,
    input  logic [ADDR_W-1:0] start_read_register_addr,
    input  logic              is_write,
    output logic [DATA_W-1:0] data_read_from_reg,
    output logic              serial_out,
    output logic              spi_clk,
    output logic              write_complete,
    output logic              read_complete,
    output logic              fifo_wr_en
);
    state_t                     r_state;
    logic                       r_cmd_prev;
    logic                       r_is_write;
    logic                       r_zero_rd;
    logic [ADDR_W+DATA_W-1:0]   r_tx;
    logic [DATA_W-2:0]          r_rx;
    logic [CNT_W-1:0]           r_bit_cnt;
    logic [CNT_W-1:0]           r_total;

    logic                       w_start;
    logic                       w_byte_end;
    logic [CNT_W-1:0]           w_next_cnt;

    assign w_start    = (r_state == IDLE) && new_command && !r_cmd_prev;
    assign w_next_cnt = r_bit_cnt + 16'd1;
    // Data bits start at index HDR_BITS, so a byte ends when (cnt - HDR_BITS) % 8 == 7.
    assign w_byte_end = (r_bit_cnt[2:0] - 3'(HDR_BITS)) == 3'd7;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state            <= IDLE;
            r_cmd_prev         <= 1'b0;
            r_is_write         <= 1'b0;
            r_zero_rd          <= 1'b0;
            r_tx               <= '0;
            r_rx               <= '0;
            r_bit_cnt          <= '0;
            r_total            <= '0;
            data_read_from_reg <= '0;
            serial_out         <= 1'b0;
            spi_clk            <= 1'b0;
            write_complete     <= 1'b0;
            read_complete      <= 1'b0;
            fifo_wr_en         <= 1'b0;
        end else begin
            r_cmd_prev     <= new_command;
            write_complete <= 1'b0;
            read_complete  <= 1'b0;
            fifo_wr_en     <= 1'b0;

            case (r_state)
                IDLE: begin
                    spi_clk    <= 1'b0;
                    serial_out <= 1'b0;
                    if (w_start) begin
                        r_is_write <= is_write;
                        r_bit_cnt  <= '0;
                        r_total    <= frame_bits(is_write, num_regs_to_read);
                        r_tx       <= {(is_write ? write_register_addr : start_read_register_addr),
                                       (is_write ? write_data : {DATA_W{1'b0}})};
                        if (!is_write && (num_regs_to_read == '0)) begin
                            r_state   <= DONE;
                            r_zero_rd <= 1'b1;
                        end else begin
                            r_state    <= HDR;
                            serial_out <= is_write ? RW_WRITE : RW_READ;
                        end
                    end
                end

                HDR, WDATA, RDATA: begin
                    if (!spi_clk) begin
                        spi_clk <= 1'b1;
                        if (r_state == RDATA) begin
                            r_rx <= {r_rx[DATA_W-3:0], serial_in};
                            if (w_byte_end) begin
                                data_read_from_reg <= {r_rx, serial_in};
                                fifo_wr_en         <= 1'b1;
                            end
                        end
                    end else begin
                        spi_clk   <= 1'b0;
                        r_bit_cnt <= w_next_cnt;
                        if (w_next_cnt == r_total) begin
                            r_state        <= DONE;
                            serial_out     <= 1'b0;
                            write_complete <= r_is_write;
                            read_complete  <= !r_is_write;
                        end else begin
                            // Zeros shift in behind the address, so reads drive 0 in the data phase.
                            serial_out <= r_tx[ADDR_W+DATA_W-1];
                            r_tx       <= {r_tx[ADDR_W+DATA_W-2:0], 1'b0};
                            if (w_next_cnt == CNT_W'(HDR_BITS))
                                r_state <= r_is_write ? WDATA : RDATA;
                        end
                    end
                end

                DONE: begin
                    spi_clk    <= 1'b0;
                    serial_out <= 1'b0;
                    r_state    <= IDLE;
                    if (r_zero_rd) begin
                        read_complete <= 1'b1;
                        r_zero_rd     <= 1'b0;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_driver.sv
// Bench for spi_driver: table of commands, peripheral model and FIFO scoreboard.
module tb_spi_driver;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       serial_in = 1'b0;
    logic       new_command = 1'b0;
    logic       is_write = 1'b0;
    logic [7:0] write_register_addr = '0;
    logic [7:0] write_data = '0;
    logic [7:0] num_regs_to_read = '0;
    logic [7:0] start_read_register_addr = '0;
    logic [7:0] data_read_from_reg;
    logic       serial_out, spi_clk, write_complete, read_complete, fifo_wr_en;

    spi_driver dut (
        .clk                      (clk),
        .rstn                     (rstn),
        .serial_in                (serial_in),
        .new_command              (new_command),
        .write_register_addr      (write_register_addr),
        .write_data               (write_data),
        .num_regs_to_read         (num_regs_to_read),
        .start_read_register_addr (start_read_register_addr),
        .is_write                 (is_write),
        .data_read_from_reg       (data_read_from_reg),
        .serial_out               (serial_out),
        .spi_clk                  (spi_clk),
        .write_complete           (write_complete),
        .read_complete            (read_complete),
        .fifo_wr_en               (fifo_wr_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } sb_t;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] n;
        logic [7:0] rbase;
        logic [7:0] rstep;
        int         lat;
        int         nbits;
        logic [7:0] exp_rd;
    } vec_t;

    sb_t         sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          fifo_cnt = 0;
    int          wc_cnt = 0;
    int          rc_cnt = 0;
    int          last_nbits = 0;
    int          last_ones = 0;
    logic [16:0] last_frame = '0;
    logic [7:0]  resp_base = '0;
    logic [7:0]  resp_step = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Peripheral model and FIFO monitor share one process so frame bookkeeping is ordered.
    initial begin
        logic        prev_sclk;
        int          nrise;
        int          ones;
        int          idx;
        logic [16:0] sh;
        logic [7:0]  rb;
        sb_t         e;
        prev_sclk = 1'b0;
        nrise = 0;
        ones = 0;
        sh = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_sclk = 1'b0;
                nrise = 0;
                ones = 0;
                sh = '0;
                serial_in = 1'b0;
            end else begin
                if (spi_clk && !prev_sclk) begin
                    if (nrise < 17) sh = {sh[15:0], serial_out};
                    if (nrise >= 9 && serial_out) ones++;
                    nrise++;
                end
                prev_sclk = spi_clk;
                if (fifo_wr_en) begin
                    fifo_cnt++;
                    if (sb.size() == 0) begin
                        check("fifo_unexpected", {31'd0, fifo_wr_en}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("fifo_data", {24'd0, data_read_from_reg}, {24'd0, e.data});
                        check("fifo_cycle", cyc, e.cyc);
                    end
                end
                if (write_complete) wc_cnt++;
                if (read_complete) rc_cnt++;
                if (write_complete || read_complete) begin
                    last_nbits = nrise;
                    last_frame = sh;
                    last_ones = ones;
                    nrise = 0;
                    sh = '0;
                    ones = 0;
                end
                if (nrise >= 9) begin
                    idx = nrise - 9;
                    rb = 8'(resp_base + resp_step * (idx / 8));
                    serial_in = rb[7 - (idx % 8)];
                end else begin
                    serial_in = 1'b0;
                end
            end
        end
    end

    task automatic run_cmd(input vec_t v);
        int          kc;
        int          seen;
        int          fc0;
        logic        got;
        logic        wasw;
        logic [16:0] exp_frame;
        got = 1'b0;
        wasw = 1'b0;
        seen = 0;
        resp_base = v.rbase;
        resp_step = v.rstep;
        fc0 = fifo_cnt;
        @(negedge clk);
        is_write = v.wr;
        write_register_addr = v.addr;
        start_read_register_addr = v.addr;
        write_data = v.wdata;
        num_regs_to_read = v.n;
        new_command = 1'b1;
        kc = cyc + 1;
        if (!v.wr)
            for (int j = 0; j < int'(v.n); j++)
                sb.push_back('{data: 8'(v.rbase + v.rstep * j), cyc: kc + 33 + 16 * j});
        @(negedge clk);
        new_command = 1'b0;
        if (write_complete || read_complete) begin
            got = 1'b1;
            seen = cyc;
            wasw = write_complete;
        end
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            if (write_complete || read_complete) begin
                got = 1'b1;
                seen = cyc;
                wasw = write_complete;
            end
        end
        check("done_seen", {31'd0, got}, 32'd1);
        check("done_latency", seen - kc, v.lat);
        check("done_kind", {31'd0, wasw}, {31'd0, v.wr});
        @(negedge clk);
        check("done_width", {30'd0, write_complete, read_complete}, 32'd0);
        exp_frame = v.wr ? {1'b1, v.addr, v.wdata} : ((v.n == 0) ? 17'd0 : {1'b0, v.addr, 8'h00});
        check("frame_bits", last_nbits, v.nbits);
        check("frame_content", {15'd0, last_frame}, {15'd0, exp_frame});
        if (!v.wr) check("read_pico_zero", last_ones, 0);
        check("fifo_count", fifo_cnt - fc0, v.wr ? 0 : int'(v.n));
        check("sb_empty", sb.size(), 0);
        check("last_byte", {24'd0, data_read_from_reg}, {24'd0, v.exp_rd});
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[6];
    vec_t vfinal;
    int   wc0;

    initial begin
        vecs[0] = '{1'b1, 8'h01, 8'hF0, 8'h00, 8'h00, 8'h00, 34,  17,  8'h00};
        vecs[1] = '{1'b0, 8'h04, 8'h00, 8'h01, 8'hA5, 8'h00, 34,  17,  8'hA5};
        vecs[2] = '{1'b0, 8'h04, 8'h00, 8'h38, 8'h00, 8'h01, 914, 457, 8'h37};
        vecs[3] = '{1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1,   0,   8'h37};
        vecs[4] = '{1'b1, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 34,  17,  8'h37};
        vecs[5] = '{1'b0, 8'h80, 8'h00, 8'h03, 8'h3C, 8'h07, 66,  33,  8'h4A};
        vfinal  = '{1'b1, 8'h7E, 8'h81, 8'h00, 8'h00, 8'h00, 34,  17,  8'h00};

        repeat (3) @(negedge clk);
        check("reset_outputs", {19'd0, serial_out, spi_clk, write_complete, read_complete,
                                fifo_wr_en, data_read_from_reg}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

        // Request held high for the whole frame, with an extra edge while busy.
        wc0 = wc_cnt;
        @(negedge clk);
        is_write = 1'b1;
        write_register_addr = 8'h33;
        write_data = 8'hC3;
        new_command = 1'b1;
        repeat (10) @(negedge clk);
        new_command = 1'b0;
        @(negedge clk);
        new_command = 1'b1;
        repeat (90) @(negedge clk);
        check("held_one_frame", wc_cnt - wc0, 1);
        check("held_frame_bits", last_nbits, 17);
        check("held_frame", {15'd0, last_frame}, {15'd0, 1'b1, 8'h33, 8'hC3});
        check("held_idle_clk", {31'd0, spi_clk}, 32'd0);
        new_command = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a write.
        wc0 = wc_cnt;
        @(negedge clk);
        is_write = 1'b1;
        write_register_addr = 8'h5A;
        write_data = 8'h0F;
        new_command = 1'b1;
        repeat (2) @(negedge clk);
        new_command = 1'b0;
        repeat (12) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midreset_outputs", {19'd0, serial_out, spi_clk, write_complete, read_complete,
                                   fifo_wr_en, data_read_from_reg}, 32'd0);
        repeat (3) @(negedge clk);
        check("midreset_hold", {30'd0, spi_clk, serial_out}, 32'd0);
        rstn = 1'b1;
        repeat (50) @(negedge clk);
        check("midreset_no_done", wc_cnt - wc0, 0);
        run_cmd(vfinal);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
